// File: rtl/multi_ch_clk_divider.sv
// NUM_CH independent divided clocks with tick strobes and a valid/ready half-period write port.
// Define CLK_DIV_STATUS_EN to add the cfg_pending and cfg_err status outputs.
module multi_ch_clk_divider #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int CH_W     = 2,
  parameter int DEF_HALF = 250000
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
`ifdef CLK_DIV_STATUS_EN
  ,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic              cfg_err
`endif
);

  localparam int DEF_HALF_C = (DEF_HALF < 1) ? 1 : DEF_HALF;

  logic [CNT_W-1:0]  count_q     [NUM_CH];
  logic [CNT_W-1:0]  count_d     [NUM_CH];
  logic [CNT_W-1:0]  half_q      [NUM_CH];
  logic [CNT_W-1:0]  half_d      [NUM_CH];
  logic [CNT_W-1:0]  pend_half_q [NUM_CH];
  logic [CNT_W-1:0]  pend_half_d [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] wr_sel, term, apply;
  logic [(2**CH_W)-1:0] pend_pad;
  logic              wr_acc;
  logic [CNT_W-1:0]  wr_half;

  // Channels beyond NUM_CH read as never pending, so writes to them are always accepted.
  always_comb begin
    pend_pad             = '0;
    pend_pad[NUM_CH-1:0] = pending_q;
  end

  assign cfg_ready = !pend_pad[cfg_ch];
  assign wr_acc    = cfg_valid && cfg_ready;
  assign wr_half   = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
  assign clk_out   = clk_q;
  assign tick      = tick_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every next-state value gets a default before any branch, so no latch is inferred.
      count_d[i]     = count_q[i];
      half_d[i]      = half_q[i];
      pend_half_d[i] = pend_half_q[i];
      pending_d[i]   = pending_q[i];
      clk_d[i]       = clk_q[i];
      tick_d[i]      = 1'b0;
      apply[i]       = 1'b0;
      wr_sel[i]      = wr_acc && (cfg_ch == CH_W'(i));
      term[i]        = (count_q[i] == half_q[i] - CNT_W'(1));

      if (sync_restart || !ch_en[i]) begin
        count_d[i] = '0;
        clk_d[i]   = 1'b0;
        apply[i]   = pending_q[i];
      end else if (term[i]) begin
        count_d[i] = '0;
        clk_d[i]   = !clk_q[i];
        tick_d[i]  = !clk_q[i];
        apply[i]   = pending_q[i];
      end else begin
        count_d[i] = count_q[i] + CNT_W'(1);
      end

      // Half only changes at a count reset, so the running half-cycle is never cut short.
      if (apply[i]) begin
        half_d[i]    = pend_half_q[i];
        pending_d[i] = 1'b0;
      end

      // A write is only accepted while not pending, so it never collides with apply.
      if (wr_sel[i]) begin
        if (sync_restart) begin
          half_d[i] = wr_half;
        end else begin
          pend_half_d[i] = wr_half;
          pending_d[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i] <= '0;
        half_q[i]  <= CNT_W'(DEF_HALF_C);
      end
      pending_q <= '0;
      clk_q     <= '0;
      tick_q    <= '0;
    end else begin
      count_q   <= count_d;
      half_q    <= half_d;
      pending_q <= pending_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  // NOTE: the pending half-period store has no reset; it is only read while its pending bit is set.
  always_ff @(posedge clk_50MHz) begin
    pend_half_q <= pend_half_d;
  end

`ifdef CLK_DIV_STATUS_EN
  logic err_q;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (wr_acc && ((cfg_half == '0) || (int'(cfg_ch) >= NUM_CH))) begin
      err_q <= 1'b1;
    end
  end

  assign cfg_pending = pending_q;
  assign cfg_err     = err_q;
`endif

endmodule

// File: tb/tb_multi_ch_clk_divider.sv
// Directed, table-driven bench for multi_ch_clk_divider with DEF_HALF = 5.
module tb_multi_ch_clk_divider;

  logic       clk_50MHz = 1'b0;
  logic       reset;
  logic [3:0] ch_en;
  logic       sync_restart;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [31:0] cfg_half;
  logic [3:0] clk_out;
  logic [3:0] tick;
`ifdef CLK_DIV_STATUS_EN
  logic [3:0] cfg_pending;
  logic       cfg_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  multi_ch_clk_divider #(
    .NUM_CH  (4),
    .CNT_W   (32),
    .CH_W    (2),
    .DEF_HALF(5)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .reset       (reset),
    .ch_en       (ch_en),
    .sync_restart(sync_restart),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_half    (cfg_half),
    .clk_out     (clk_out),
    .tick        (tick)
`ifdef CLK_DIV_STATUS_EN
    ,
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err)
`endif
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // rs/vld pulse on the first of n edges only; rst/en/ch/half are held for all n edges.
  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  en;
    logic        rs;
    logic        vld;
    logic [1:0]  ch;
    logic [31:0] half;
    int          n;
    logic        rdy0;
    logic [3:0]  clk;
    logic [3:0]  tk;
    logic        rdy;
    logic        err;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_edge();
    @(posedge clk_50MHz);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    ch_en        = 4'hF;
    sync_restart = 1'b0;
    cfg_valid    = 1'b0;
    cfg_ch       = 2'd0;
    cfg_half     = 32'd0;

    //           name             rst en    rs vld ch    half    n rdy0 clk   tk    rdy err
    vq.push_back('{"t1_rise",       0, 4'hF, 0, 0, 2'd0, 32'd0, 5, 1, 4'hF, 4'hF, 1, 0});
    vq.push_back('{"t1_tick_width", 0, 4'hF, 0, 0, 2'd0, 32'd0, 1, 1, 4'hF, 4'h0, 1, 0});
    vq.push_back('{"t1_fall",       0, 4'hF, 0, 0, 2'd0, 32'd0, 4, 1, 4'h0, 4'h0, 1, 0});
    vq.push_back('{"t1_rise2",      0, 4'hF, 0, 0, 2'd0, 32'd0, 5, 1, 4'hF, 4'hF, 1, 0});
    vq.push_back('{"t2_write",      0, 4'hF, 0, 1, 2'd1, 32'd3, 2, 1, 4'hF, 4'h0, 0, 0});
    vq.push_back('{"t2_blocked",    0, 4'hF, 0, 1, 2'd1, 32'd7, 3, 0, 4'h0, 4'h0, 1, 0});
    vq.push_back('{"t2_ch1_rise",   0, 4'hF, 0, 0, 2'd1, 32'd0, 3, 1, 4'h2, 4'h2, 1, 0});
    vq.push_back('{"t2_ch1_fall",   0, 4'hF, 0, 0, 2'd1, 32'd0, 3, 1, 4'hD, 4'h0, 1, 0});
    vq.push_back('{"t2_ch1_rise2",  0, 4'hF, 0, 0, 2'd1, 32'd0, 3, 1, 4'hF, 4'h2, 1, 0});
    vq.push_back('{"t3_write0",     0, 4'hF, 0, 1, 2'd2, 32'd0, 1, 1, 4'h2, 4'h0, 0, 1});
    vq.push_back('{"t3_held",       0, 4'hF, 0, 0, 2'd2, 32'd0, 4, 0, 4'h0, 4'h0, 0, 1});
    vq.push_back('{"t3_apply",      0, 4'hF, 0, 0, 2'd2, 32'd0, 1, 0, 4'hF, 4'hF, 1, 1});
    vq.push_back('{"t3_fast_a",     0, 4'hF, 0, 0, 2'd2, 32'd0, 1, 1, 4'hB, 4'h0, 1, 1});
    vq.push_back('{"t3_fast_b",     0, 4'hF, 0, 0, 2'd2, 32'd0, 1, 1, 4'hF, 4'h4, 1, 1});
    vq.push_back('{"t3_fast_c",     0, 4'hF, 0, 0, 2'd2, 32'd0, 1, 1, 4'h9, 4'h0, 1, 1});
    vq.push_back('{"t4_wr_ch0",     0, 4'hF, 0, 1, 2'd0, 32'd3, 1, 1, 4'hD, 4'h4, 0, 1});
    vq.push_back('{"t4_wr_ch3",     0, 4'hF, 0, 1, 2'd3, 32'd7, 1, 1, 4'h0, 4'h0, 0, 1});
    vq.push_back('{"t4_wr_ch1",     0, 4'hF, 0, 1, 2'd1, 32'd4, 1, 1, 4'h6, 4'h6, 0, 1});
    vq.push_back('{"t4_restart",    0, 4'hF, 1, 1, 2'd2, 32'd5, 1, 1, 4'h0, 4'h0, 1, 1});
    vq.push_back('{"t4_rise3",      0, 4'hF, 0, 0, 2'd2, 32'd0, 3, 1, 4'h1, 4'h1, 1, 1});
    vq.push_back('{"t4_rise4",      0, 4'hF, 0, 0, 2'd2, 32'd0, 1, 1, 4'h3, 4'h2, 1, 1});
    vq.push_back('{"t4_rise5",      0, 4'hF, 0, 0, 2'd2, 32'd0, 1, 1, 4'h7, 4'h4, 1, 1});
    vq.push_back('{"t4_rise7",      0, 4'hF, 0, 0, 2'd2, 32'd0, 2, 1, 4'hE, 4'h8, 1, 1});
    vq.push_back('{"t5_pre",        0, 4'hF, 0, 0, 2'd0, 32'd0, 1, 1, 4'hC, 4'h0, 1, 1});
    vq.push_back('{"t5_pre2",       0, 4'hF, 0, 0, 2'd0, 32'd0, 1, 1, 4'hD, 4'h1, 1, 1});
    vq.push_back('{"t5_dis",        0, 4'hE, 0, 0, 2'd0, 32'd0, 1, 1, 4'h8, 4'h0, 1, 1});
    vq.push_back('{"t5_dis_wr",     0, 4'hE, 0, 1, 2'd0, 32'd2, 1, 1, 4'h8, 4'h0, 0, 1});
    vq.push_back('{"t5_dis_apply",  0, 4'hE, 0, 0, 2'd0, 32'd0, 1, 0, 4'hA, 4'h2, 1, 1});
    vq.push_back('{"t5_dis_end",    0, 4'hE, 0, 0, 2'd0, 32'd0, 1, 1, 4'hA, 4'h0, 1, 1});
    vq.push_back('{"t5_reen",       0, 4'hF, 0, 0, 2'd0, 32'd0, 1, 1, 4'h2, 4'h0, 1, 1});
    vq.push_back('{"t5_first_tick", 0, 4'hF, 0, 0, 2'd0, 32'd0, 1, 1, 4'h7, 4'h5, 1, 1});
    vq.push_back('{"t6_wr",         0, 4'hF, 0, 1, 2'd3, 32'd9, 1, 1, 4'h5, 4'h0, 0, 1});
    vq.push_back('{"t6_reset",      1, 4'hF, 0, 0, 2'd3, 32'd0, 1, 0, 4'h0, 4'h0, 1, 0});
    vq.push_back('{"t6_def_rise",   0, 4'hF, 0, 0, 2'd3, 32'd0, 5, 1, 4'hF, 4'hF, 1, 0});
    vq.push_back('{"t6_def_fall",   0, 4'hF, 0, 0, 2'd3, 32'd0, 5, 1, 4'h0, 4'h0, 1, 0});

    // All outputs must stay low while reset is held.
    for (int k = 0; k < 3; k++) begin
      tick_edge();
      check($sformatf("rst_clk_%0d", k), 32'(clk_out), 32'h0);
      check($sformatf("rst_tick_%0d", k), 32'(tick), 32'h0);
      check($sformatf("rst_ready_%0d", k), 32'(cfg_ready), 32'h1);
    end
    reset = 1'b0;

    foreach (vq[r]) begin
      reset        = vq[r].rst;
      ch_en        = vq[r].en;
      sync_restart = vq[r].rs;
      cfg_valid    = vq[r].vld;
      cfg_ch       = vq[r].ch;
      cfg_half     = vq[r].half;
      #1;
      check({vq[r].name, "_ready_pre"}, 32'(cfg_ready), 32'(vq[r].rdy0));
      for (int k = 0; k < vq[r].n; k++) begin
        tick_edge();
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;
      end
      check({vq[r].name, "_clk"}, 32'(clk_out), 32'(vq[r].clk));
      check({vq[r].name, "_tick"}, 32'(tick), 32'(vq[r].tk));
      check({vq[r].name, "_ready"}, 32'(cfg_ready), 32'(vq[r].rdy));
`ifdef CLK_DIV_STATUS_EN
      check({vq[r].name, "_err"}, 32'(cfg_err), 32'(vq[r].err));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_ch_clk_divider.md
Name: multi_ch_clk_divider

Overview:
Parametrised successor to the single fixed 100 Hz divider. Generates NUM_CH independent divided clocks and matching one-cycle tick strobes from the 50 MHz system clock. Each channel's half-period is reprogrammable at runtime through a valid/ready write port, with glitch-free updates. Feeds display scanning, debounce sampling and stopwatch timing logic that currently each instantiate their own fixed divider.

Parameters:
NUM_CH, 4, number of output channels (1..16)
CNT_W, 32, width of per-channel counter and half-period value
CH_W, 2, width of cfg_ch; must satisfy 2**CH_W >= NUM_CH
DEF_HALF, 250000, half-period in clk cycles loaded into every channel at reset (100 Hz at 50 MHz)

Ports:
clk_50MHz  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
ch_en  in  NUM_CH  per-channel run enable
sync_restart  in  1  one-cycle pulse; phase-aligns all channels
cfg_valid  in  1  configuration write request
cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
cfg_ch  in  CH_W  target channel of write
cfg_half  in  CNT_W  new half-period in cycles
clk_out  out  NUM_CH  divided square-wave outputs, registered
tick  out  NUM_CH  one-cycle strobe on each clk_out rising transition, registered

Behaviour:
- One clock; reset is synchronous and active-high. Clock port clk_50MHz, reset port reset.
- Reset: every count = 0, half = DEF_HALF, pending = 0, clk_out = 0, tick = 0. Reset has priority over everything else.
- Per channel, enabled: terminal count when count == half-1. On a terminal count: count <= 0, clk_out toggles, and tick <= 1 if clk_out goes 0->1. Otherwise count increments and tick <= 0. Output period is 2*half cycles, 50% duty.
- Half-period value 0 is clamped to 1: clk_out toggles every cycle (25 MHz).
- Disabled (ch_en[i] = 0): count held 0, clk_out forced 0 on the next edge, tick = 0.
- Enable rising edge: counting starts from 0. The first clk_out rise and tick occur half cycles after the first enabled edge.
- Config handshake:
  - cfg_ready = !pending[cfg_ch], combinational from registered state.
  - An accepted write stores cfg_half in pend_half[cfg_ch] and sets pending.
  - cfg_ch >= NUM_CH: accepted and discarded (cfg_ready = 1).
- Update application:
  - A pending value is loaded into half on that channel's next terminal-count edge, together with the toggle. No shortened or stretched half-cycle is produced.
  - If the channel is disabled, the update applies on the edge after acceptance.
  - Pending clears on the same edge the update applies.
- sync_restart: all channels' count <= 0, clk_out <= 0, tick <= 0. Any pending updates apply on that edge.
- Simultaneous write and restart: the write is accepted and applied on the same edge. A write accepted on the edge where that channel terminal-counts is held pending until the following terminal count.
- Counter never exceeds half-1. If half is reduced while count > new half-1, this cannot occur because updates apply only at count reset.

Optional Feature:
Macro CLK_DIV_STATUS_EN.
- Defined: adds two outputs.
  - cfg_pending [NUM_CH]: per-channel pending bits.
  - cfg_err [1]: sticky; set on an accepted write with cfg_half == 0 or cfg_ch >= NUM_CH; cleared only by reset.
  - A half = 0 write is still clamped to 1.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset, all ch_en = 1, DEF_HALF overridden to 5 -> clk_out period 10 cycles; tick high 1 cycle, 5 cycles after reset release, then every 10; all outputs 0 during reset.
2. Channel 1 at half = 5, write cfg_half = 3 mid half-cycle -> current half-cycle completes at 5 cycles, then period becomes 6; cfg_ready low for cfg_ch = 1 until applied; second write while pending not accepted.
3. Write cfg_half = 0 to channel 2 -> clk_out[2] toggles every cycle, tick[2] every 2 cycles; with CLK_DIV_STATUS_EN, cfg_err = 1 and stays 1 until reset.
4. Channels at half 3/4/5/7, pulse sync_restart -> all clk_out = 0 and count = 0 next edge; rising edges after 3/4/5/7 cycles.
5. Drop ch_en[0] for 4 cycles mid-period, then re-raise -> clk_out[0] = 0 while disabled; first tick exactly half cycles after re-enable; a write made while disabled applies the next cycle.
6. Assert reset mid-operation with a pending update -> next edge all outputs 0, half back to DEF_HALF, pending cleared, cfg_ready = 1.
